// File: rtl/dmem_responder_if.sv
// Request/response bundle between the KGP-RISC controller (master) and the data-memory responder (slave).
// A request is taken only when the responder is idle. resp_valid is a one-cycle pulse, and resp_rdata/resp_err are only meaningful while it is high.
interface dmem_responder_if;
  logic        req_read;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_read, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_read, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with WAIT_CYCLES wait states between acceptance and a one-cycle response.
// Define DMEM_ALIGN_CHECK_EN to flag addr[1:0] != 0 as an error; otherwise those bits are ignored.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus,
  output logic [1:0]      state_o
);

  localparam int         AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
`ifdef DMEM_ALIGN_CHECK_EN
  localparam logic ALIGN_CHECK = 1'b1;
`else
  localparam logic ALIGN_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            op_read_q, op_read_d;
  logic            op_write_q, op_write_d;
  logic            err_q, err_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            resp_err_q, resp_err_d;
  logic            mem_we;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            req_any;
  logic            req_err;
  logic [AW-1:0]   req_idx;

  always_comb begin
    req_any = bus.req_read | bus.req_write;
    req_idx = bus.req_addr[AW+1:2];
    req_err = (bus.req_read & bus.req_write)
            | ((bus.req_addr >> (AW + 2)) != 32'd0)
            | (ALIGN_CHECK & (bus.req_addr[1:0] != 2'b00));
  end

  // Completion data is taken straight from the request when WAIT_CYCLES=0,
  // otherwise from the latched transaction.
  logic            fill_read;
  logic            fill_err;
  logic [AW-1:0]   fill_idx;
  logic [31:0]     fill_rdata;

  always_comb begin
    if (state_q == S_IDLE) begin
      fill_read = bus.req_read;
      fill_err  = req_err;
      fill_idx  = req_idx;
    end else begin
      fill_read = op_read_q;
      fill_err  = err_q;
      fill_idx  = idx_q;
    end
    fill_rdata = (fill_read && !fill_err) ? mem[fill_idx] : 32'd0;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_read_d  = op_read_q;
    op_write_d = op_write_q;
    err_d      = err_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    resp_err_d = resp_err_q;
    mem_we     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_any) begin
          op_read_d  = bus.req_read;
          op_write_d = bus.req_write;
          idx_d      = req_idx;
          wdata_d    = bus.req_wdata;
          err_d      = req_err;
          cnt_d      = WAIT_LD;
          if (WAIT_CYCLES == 0) begin
            state_d    = S_RESP;
            rdata_d    = fill_rdata;
            resp_err_d = fill_err;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = S_RESP;
          rdata_d    = fill_rdata;
          resp_err_d = fill_err;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        // The store commits as RESP ends, so a following load sees it.
        mem_we  = op_write_q & ~err_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      op_read_q  <= 1'b0;
      op_write_q <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_read_q  <= op_read_d;
      op_write_q <= op_write_d;
      err_q      <= err_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      resp_err_q <= resp_err_d;
    end
  end

  // Memory contents survive reset; a reset on the commit edge drops the store.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign state_o        = state_q;

endmodule
